// File: rtl/alu_muldiv_seq_pkg.sv
// Shared alu definitions: ALU_control opcodes, bonus_control value and the
// sequencer FSM state encoding.
// Latency: n/a (constants only). Backpressure: n/a.
package alu_muldiv_seq_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [2:0] BONUS_NONE = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage : alu_muldiv_seq_pkg

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) sequencer driving an external alu.
// Latency: start edge E, WIDTH steps at E+1..E+WIDTH, done_o high after E+WIDTH+1; div-by-zero done after E+1.
// Backpressure: none; start_i is accepted only while busy_o is low, otherwise ignored.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start_i, op_i, a_i, b_i       request (op_i 0 = mul, 1 = div), operands
//   busy_o, done_o                busy from accept until done drops; one-cycle done pulse
//   hi_o, lo_o, dbz_o             product hi/lo or remainder/quotient; divide-by-zero flag
//   alu_src1_o .. alu_bonus_o     operand/opcode drive to the external alu
//   alu_result_i .. alu_overflow_i results back from the alu (zero/overflow unused)
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] alu_src1_o,
  output logic [WIDTH-1:0] alu_src2_o,
  output logic [3:0]       alu_ctrl_o,
  output logic [2:0]       alu_bonus_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_cout_i,
  input  logic             alu_zero_i,
  input  logic             alu_overflow_i
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand or divisor
  logic [CNT_W-1:0] count_q, count_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  // Divide step: partial remainder shifted left by one, pulling in the next
  // dividend bit. The bit shifted out (msb) makes it exceed WIDTH bits, in
  // which case the subtract always succeeds regardless of the alu borrow.
  logic [WIDTH-1:0] div_sh;
  logic             div_msb;

  // The alu flags other than cout carry no information for mul/div.
  logic unused_alu_flags;
  assign unused_alu_flags = alu_zero_i ^ alu_overflow_i;

  assign div_sh  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign div_msb = hi_q[WIDTH-1];

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mcand_d    = mcand_q;
    count_d    = count_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;
    alu_src1_o = '0;
    alu_src2_o = '0;
    alu_ctrl_o = ALU_AND;

    case (state_q)
      ST_IDLE: begin
        // done_q still high means the completion pulse is being shown and
        // busy_o is still asserted, so a request here is ignored.
        if (start_i && !done_q) begin
          hi_d    = '0;
          lo_d    = a_i;
          mcand_d = b_i;
          count_d = '0;
          dbz_d   = 1'b0;
          if (!op_i) begin
            state_d = ST_MUL;
          end else if (b_i != '0) begin
            state_d = ST_DIV;
          end else begin
            hi_d    = a_i;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_MUL: begin
        alu_src1_o = hi_q;
        alu_src2_o = lo_q[0] ? mcand_q : '0;
        alu_ctrl_o = ALU_ADD;
        // Shift the (WIDTH+1)-bit sum and the multiplier right as one register.
        hi_d    = {alu_cout_i, alu_result_i[WIDTH-1:1]};
        lo_d    = {alu_result_i[0], lo_q[WIDTH-1:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_STEP) begin
          state_d = ST_DONE;
        end
      end

      ST_DIV: begin
        alu_src1_o = div_sh;
        alu_src2_o = mcand_q;
        alu_ctrl_o = ALU_SUB;
        if (div_msb || alu_cout_i) begin
          hi_d = alu_result_i;
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_sh;
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_STEP) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      count_q <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      count_q <= count_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE) || done_q;
  assign done_o      = done_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign dbz_o       = dbz_q;
  assign alu_bonus_o = BONUS_NONE;

endmodule : alu_muldiv_seq

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq paired with a behavioural combinational alu.
// Latency: n/a. Backpressure: n/a.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;
  logic [W-1:0] alu_src1, alu_src2, alu_result;
  logic [3:0]   alu_ctrl;
  logic [2:0]   alu_bonus;
  logic         alu_cout, alu_zero, alu_overflow;
  logic [W:0]   alu_wide;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_add    = 0;
  int n_sub    = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    logic         is_div;
    int           start_cyc;
    int           lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo), .dbz_o(dbz),
    .alu_src1_o(alu_src1), .alu_src2_o(alu_src2), .alu_ctrl_o(alu_ctrl),
    .alu_bonus_o(alu_bonus), .alu_result_i(alu_result), .alu_cout_i(alu_cout),
    .alu_zero_i(alu_zero), .alu_overflow_i(alu_overflow)
  );

  // Behavioural alu: cout on SUB is the no-borrow flag.
  always_comb begin
    alu_wide = '0;
    case (alu_ctrl)
      ALU_ADD: alu_wide = {1'b0, alu_src1} + {1'b0, alu_src2};
      ALU_SUB: alu_wide = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
      ALU_AND: alu_wide = {1'b0, alu_src1 & alu_src2};
      ALU_OR:  alu_wide = {1'b0, alu_src1 | alu_src2};
      ALU_NOR: alu_wide = {1'b0, ~(alu_src1 | alu_src2)};
      ALU_SLT: alu_wide = {32'd0, alu_src1 < alu_src2};
      default: alu_wide = '0;
    endcase
  end
  assign alu_result   = alu_wide[W-1:0];
  assign alu_cout     = alu_wide[W];
  assign alu_zero     = (alu_wide[W-1:0] == '0);
  assign alu_overflow = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse and tallies alu opcodes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_ctrl == ALU_ADD) n_add++;
      else if (alu_ctrl == ALU_SUB) n_sub++;
      else if (alu_ctrl != ALU_AND) check("alu_ctrl_legal", 64'(alu_ctrl), 64'(ALU_AND));
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("hi", 64'(hi), 64'(e.hi));
          check("lo", 64'(lo), 64'(e.lo));
          check("dbz", 64'(dbz), 64'(e.dbz));
          check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
          check("add_steps", 64'(n_add), (e.is_div || e.dbz) ? 64'd0 : 64'd32);
          check("sub_steps", 64'(n_sub), (e.is_div && !e.dbz) ? 64'd32 : 64'd0);
          check("bonus", 64'(alu_bonus), 64'(BONUS_NONE));
        end
        n_add = 0;
        n_sub = 0;
      end
    end else begin
      n_add = 0;
      n_sub = 0;
    end
  end

  // Drive one request and push its expected response. Returns at the
  // negedge after the accepting edge, with start_i already dropped.
  task automatic start_op(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    e.hi        = ehi;
    e.lo        = elo;
    e.dbz       = edbz;
    e.is_div    = o;
    e.start_cyc = cyc + 1;
    e.lat       = edbz ? 1 : W + 1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      check("done_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  task automatic run_op(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz);
    start_op(o, av, bv, ehi, elo, edbz);
    wait_done();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] prod;
    logic [W-1:0] ra, rb;

    // Reset state
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_ctrl", 64'(alu_ctrl), 64'(ALU_AND));
    check("idle_src1", 64'(alu_src1), 64'd0);
    check("idle_src2", 64'(alu_src2), 64'd0);

    // Directed multiply / divide
    run_op(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_op(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op(1'b0, 32'd0, 32'd12345, 32'd0, 32'd0, 1'b0);
    run_op(1'b1, 32'd6, 32'd7, 32'd6, 32'd0, 1'b0);

    // Restart pulse mid-multiply is ignored; busy spans the whole operation
    start_op(1'b0, 32'd1000, 32'd1000, 32'd0, 32'd1000000, 1'b0);
    for (int i = 0; i < W + 2; i++) begin
      check("busy_during_op", 64'(busy), 64'd1);
      if (i == 3) begin
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd9;
        b     = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_after_done", 64'(busy), 64'd0);
    wait_done();
    check("hold_lo", 64'(lo), 64'd1000000);

    // Reset at step 10 of a divide aborts without a done pulse
    start_op(1'b1, 32'hDEAD_BEEF, 32'd19, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_dbz", 64'(dbz), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run_op(1'b0, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0);

    // Randomised operations against a reference model
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      if (i[0] == 1'b0) begin
        prod = 64'(ra) * 64'(rb);
        run_op(1'b0, ra, rb, prod[63:32], prod[31:0], 1'b0);
      end else if (rb == '0) begin
        run_op(1'b1, ra, rb, ra, 32'hFFFF_FFFF, 1'b1);
      end else begin
        run_op(1'b1, ra, rb, ra % rb, ra / rb, 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_muldiv_seq
